// File: rtl/multibyte_alu_seq_pkg.sv
// Shared task codes, legal-op set and FSM encoding for the multi-byte ALU sequencer.
package multibyte_alu_seq_pkg;

   localparam logic [3:0] OP_ADC = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_NEG = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_SBB = 4'h7;
   localparam logic [3:0] OP_SUB = 4'h8;
   localparam logic [3:0] OP_XOR = 4'h9;
   localparam logic [3:0] OP_RLC = 4'hA;
   localparam logic [3:0] OP_RRC = 4'hB;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_ADC, OP_ADD, OP_AND, OP_NOT, OP_OR,
         OP_SBB, OP_SUB, OP_XOR, OP_RLC, OP_RRC: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   // Byte address for index idx; RRC walks from the MSB byte down, wrapping mod 256.
   function automatic logic [7:0] byte_addr(input logic [7:0] base, input logic [2:0] len,
                                            input logic [3:0] idx, input logic desc);
      logic [7:0] off;
      off = desc ? ({5'b0, len} - {4'b0, idx}) : {4'b0, idx};
      return base + off;
   endfunction

endpackage

// File: rtl/multibyte_alu_seq_cpu_arith.sv
// Single-byte ALU; Carry_o is "no borrow" for subtract-type tasks.
module CPU_Arith
   import multibyte_alu_seq_pkg::*;
(
   input  logic [7:0] A_i,
   input  logic [7:0] B_i,
   input  logic [3:0] Task_i,
   input  logic       Carry_i,
   output logic [7:0] Y_o,
   output logic       Carry_o
);

   logic [8:0] sum;

   always_comb begin
      sum     = '0;
      Y_o     = '0;
      Carry_o = 1'b0;
      case (Task_i)
         OP_ADC: begin sum = {1'b0, A_i} + {1'b0, B_i} + {8'b0, Carry_i}; Y_o = sum[7:0]; Carry_o = sum[8]; end
         OP_ADD: begin sum = {1'b0, A_i} + {1'b0, B_i};                  Y_o = sum[7:0]; Carry_o = sum[8]; end
         OP_AND: Y_o = A_i & B_i;
         OP_NEG: begin sum = 9'h100 - {1'b0, A_i};                       Y_o = sum[7:0]; Carry_o = sum[8]; end
         OP_NOT: Y_o = ~A_i;
         OP_OR:  Y_o = A_i | B_i;
         OP_SBB: begin sum = {1'b0, A_i} - {1'b0, B_i} - {8'b0, Carry_i}; Y_o = sum[7:0]; Carry_o = ~sum[8]; end
         OP_SUB: begin sum = {1'b0, A_i} - {1'b0, B_i};                  Y_o = sum[7:0]; Carry_o = ~sum[8]; end
         OP_XOR: Y_o = A_i ^ B_i;
         OP_RLC: begin Y_o = {A_i[6:0], Carry_i}; Carry_o = A_i[7]; end
         OP_RRC: begin Y_o = {Carry_i, A_i[7:1]}; Carry_o = A_i[0]; end
         default: ;
      endcase
   end

endmodule

// File: rtl/multibyte_alu_seq.sv
// Sequences one byte-wide CPU_Arith over an N-byte memory operand, one byte per cycle.
module multibyte_alu_seq
   import multibyte_alu_seq_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [3:0] Op,
   input  logic [2:0] Length,
   input  logic [7:0] Addr_A,
   input  logic [7:0] Addr_B,
   input  logic [7:0] Addr_Y,
   input  logic       Carry_Init,
   output logic [7:0] Mem_Addr_A,
   output logic [7:0] Mem_Addr_B,
   input  logic [7:0] Mem_RdData_A,
   input  logic [7:0] Mem_RdData_B,
   output logic       Mem_Wr,
   output logic [7:0] Mem_WrAddr,
   output logic [7:0] Mem_WrData,
   output logic       Busy,
   output logic       Done,
   output logic       Error,
   output logic       Carry_Out,
   output logic       Zero_Out
);

   state_e     state_q;
   logic [3:0] op_q;
   logic [2:0] len_q;
   logic [7:0] a_q, b_q, y_q;
   logic       cinit_q, carry_q, zacc_q;
   logic [3:0] cnt_q;
   logic       err_q, cout_q, zout_q;

   logic       desc, first, last, alu_cin, alu_co, byte_zero;
   logic [3:0] alu_task, rd_idx;
   logic [7:0] alu_y;

   assign desc   = (op_q == OP_RRC);
   assign first  = (cnt_q == 4'd0);
   assign last   = (cnt_q == {1'b0, len_q});
   // While byte j is consumed, byte j+1 is already being addressed.
   assign rd_idx = (state_q == S_RUN) ? cnt_q + 4'd1 : 4'd0;

   always_comb begin
      alu_task = op_q;
      alu_cin  = cinit_q;
      if (!first) begin
         case (op_q)
            OP_ADD: alu_task = OP_ADC;
            OP_SUB: alu_task = OP_SBB;
            default: ;
         endcase
         case (op_q)
            OP_ADC, OP_ADD, OP_RLC, OP_RRC: alu_cin = carry_q;
            OP_SBB, OP_SUB:                 alu_cin = ~carry_q;
            default: ;
         endcase
      end
   end

   CPU_Arith u_alu (
      .A_i     (Mem_RdData_A),
      .B_i     (Mem_RdData_B),
      .Task_i  (alu_task),
      .Carry_i (alu_cin),
      .Y_o     (alu_y),
      .Carry_o (alu_co)
   );

   assign byte_zero  = (alu_y == 8'h00);
   assign Mem_Addr_A = byte_addr(a_q, len_q, rd_idx, desc);
   assign Mem_Addr_B = byte_addr(b_q, len_q, rd_idx, desc);
   assign Mem_WrAddr = byte_addr(y_q, len_q, cnt_q, desc);
   assign Mem_WrData = alu_y;
   assign Mem_Wr     = (state_q == S_RUN);
   assign Busy       = (state_q == S_FETCH) || (state_q == S_RUN);
   assign Done       = (state_q == S_DONE);
   assign Error      = err_q;
   assign Carry_Out  = cout_q;
   assign Zero_Out   = zout_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         len_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         cinit_q <= 1'b0;
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         cout_q  <= 1'b0;
         zout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (Start) begin
               op_q    <= Op;
               len_q   <= Length;
               a_q     <= Addr_A;
               b_q     <= Addr_B;
               y_q     <= Addr_Y;
               cinit_q <= Carry_Init;
               cnt_q   <= '0;
               zacc_q  <= 1'b1;
               err_q   <= ~is_legal_op(Op);
               state_q <= is_legal_op(Op) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
               cnt_q   <= '0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               carry_q <= alu_co;
               zacc_q  <= zacc_q & byte_zero;
               cnt_q   <= cnt_q + 4'd1;
               if (last) begin
                  cout_q  <= alu_co;
                  zout_q  <= zacc_q & byte_zero;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multibyte_alu_seq.sv
// Directed vector bench for multibyte_alu_seq with a byte-wide sync-read memory model.
module tb_multibyte_alu_seq;

   logic       Clk = 1'b0;
   logic       Reset, Start, Carry_Init;
   logic [3:0] Op;
   logic [2:0] Length;
   logic [7:0] Addr_A, Addr_B, Addr_Y;
   logic [7:0] Mem_Addr_A, Mem_Addr_B, Mem_RdData_A, Mem_RdData_B;
   logic       Mem_Wr;
   logic [7:0] Mem_WrAddr, Mem_WrData;
   logic       Busy, Done, Error, Carry_Out, Zero_Out;

   logic [7:0] mem [256];
   int         n_pass = 0;
   int         n_total = 0;

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      Mem_RdData_A <= mem[Mem_Addr_A];
      Mem_RdData_B <= mem[Mem_Addr_B];
      if (Mem_Wr) mem[Mem_WrAddr] <= Mem_WrData;
   end

   multibyte_alu_seq dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Length(Length),
      .Addr_A(Addr_A), .Addr_B(Addr_B), .Addr_Y(Addr_Y), .Carry_Init(Carry_Init),
      .Mem_Addr_A(Mem_Addr_A), .Mem_Addr_B(Mem_Addr_B),
      .Mem_RdData_A(Mem_RdData_A), .Mem_RdData_B(Mem_RdData_B),
      .Mem_Wr(Mem_Wr), .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
      .Busy(Busy), .Done(Done), .Error(Error), .Carry_Out(Carry_Out), .Zero_Out(Zero_Out)
   );

   typedef struct {
      logic [3:0]  op;
      int          n;
      logic [63:0] a, b;
      logic        ci;
      logic [7:0]  aa, ab, ay;
      logic [63:0] ey;
      logic        eco, ezo, eerr;
   } vec_t;

   vec_t vt[16];

   function automatic vec_t mk(logic [3:0] op, int n, logic [63:0] a, logic [63:0] b, logic ci,
                               logic [7:0] aa, logic [7:0] ab, logic [7:0] ay,
                               logic [63:0] ey, logic eco, logic ezo, logic eerr);
      vec_t v;
      v.op = op; v.n = n; v.a = a; v.b = b; v.ci = ci;
      v.aa = aa; v.ab = ab; v.ay = ay;
      v.ey = ey; v.eco = eco; v.ezo = ezo; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      else n_pass++;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      logic [7:0]  ad;
      logic [63:0] got;
      int          edges, wr;
      for (int i = 0; i < v.n; i++) begin
         ad = v.ay + 8'(i); mem[ad] = 8'hA5;
      end
      for (int i = 0; i < v.n; i++) begin
         ad = v.aa + 8'(i); mem[ad] = v.a[8*i +: 8];
         ad = v.ab + 8'(i); mem[ad] = v.b[8*i +: 8];
      end
      Op = v.op; Length = 3'(v.n - 1); Carry_Init = v.ci;
      Addr_A = v.aa; Addr_B = v.ab; Addr_Y = v.ay; Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("v%0d_busy", id), 64'(Busy), 64'(!v.eerr));
      // Scrambled inputs and a held Start while busy must be ignored.
      Op = 4'h4; Length = 3'd0; Addr_A = 8'hC0; Addr_B = 8'hC8; Addr_Y = 8'hD0; Carry_Init = ~v.ci;
      edges = 0; wr = 0;
      while (!Done && edges < 20) begin
         if (Mem_Wr) wr++;
         @(posedge Clk);
         @(negedge Clk);
         edges++;
         Start = 1'b0;
      end
      Start = 1'b0;
      chk($sformatf("v%0d_done_lat", id), 64'(edges), v.eerr ? 64'd0 : 64'(v.n + 1));
      chk($sformatf("v%0d_writes", id), 64'(wr), v.eerr ? 64'd0 : 64'(v.n));
      chk($sformatf("v%0d_err", id), 64'(Error), 64'(v.eerr));
      chk($sformatf("v%0d_cout", id), 64'(Carry_Out), 64'(v.eco));
      chk($sformatf("v%0d_zout", id), 64'(Zero_Out), 64'(v.ezo));
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("v%0d_done_pulse", id), 64'(Done), 64'd0);
      if (!v.eerr) begin
         got = '0;
         for (int i = 0; i < v.n; i++) begin
            ad = v.ay + 8'(i); got[8*i +: 8] = mem[ad];
         end
         chk($sformatf("v%0d_y", id), got, v.ey);
      end
   endtask

   initial begin
      int dn;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      vt[0]  = mk(4'h2, 2, 64'h00FF, 64'h0001, 1'b0, 8'h10, 8'h20, 8'h30, 64'h0100, 1'b0, 1'b0, 1'b0);
      vt[1]  = mk(4'h2, 2, 64'hFFFF, 64'h0001, 1'b0, 8'h10, 8'h20, 8'h30, 64'h0000, 1'b1, 1'b1, 1'b0);
      vt[2]  = mk(4'h8, 2, 64'h0100, 64'h0001, 1'b0, 8'h10, 8'h20, 8'h30, 64'h00FF, 1'b1, 1'b0, 1'b0);
      vt[3]  = mk(4'hB, 3, 64'h000001, 64'h0, 1'b1, 8'h10, 8'h20, 8'h30, 64'h800000, 1'b1, 1'b0, 1'b0);
      vt[4]  = mk(4'h1, 4, 64'h12345678, 64'h11111111, 1'b1, 8'h10, 8'h20, 8'h30, 64'h2345678A, 1'b0, 1'b0, 1'b0);
      vt[5]  = mk(4'h3, 1, 64'hF0, 64'h3C, 1'b0, 8'h10, 8'h20, 8'h30, 64'h30, 1'b0, 1'b0, 1'b0);
      vt[6]  = mk(4'h9, 8, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, 8'h10, 8'h20, 8'h30,
                  64'h0, 1'b0, 1'b1, 1'b0);
      vt[7]  = mk(4'h6, 2, 64'h0F00, 64'h00F0, 1'b0, 8'h10, 8'h20, 8'h30, 64'h0FF0, 1'b0, 1'b0, 1'b0);
      vt[8]  = mk(4'h5, 3, 64'hFF00FF, 64'h0, 1'b0, 8'h10, 8'h20, 8'h30, 64'h00FF00, 1'b0, 1'b0, 1'b0);
      vt[9]  = mk(4'h7, 2, 64'h0005, 64'h0005, 1'b1, 8'h10, 8'h20, 8'h30, 64'hFFFF, 1'b0, 1'b0, 1'b0);
      vt[10] = mk(4'hA, 2, 64'h8001, 64'h0, 1'b0, 8'h10, 8'h20, 8'h30, 64'h0002, 1'b1, 1'b0, 1'b0);
      vt[11] = mk(4'h4, 2, 64'h0, 64'h0, 1'b0, 8'h10, 8'h20, 8'h30, 64'h0, 1'b1, 1'b0, 1'b1);
      vt[12] = mk(4'h0, 1, 64'h0, 64'h0, 1'b0, 8'h10, 8'h20, 8'h30, 64'h0, 1'b1, 1'b0, 1'b1);
      vt[13] = mk(4'h2, 1, 64'h00, 64'h00, 1'b1, 8'h10, 8'h20, 8'h30, 64'h00, 1'b0, 1'b1, 1'b0);
      vt[14] = mk(4'h2, 2, 64'h01FF, 64'h0001, 1'b0, 8'h50, 8'h20, 8'h50, 64'h0200, 1'b0, 1'b0, 1'b0);
      vt[15] = mk(4'h2, 4, 64'h00000001, 64'h000000FF, 1'b0, 8'hFE, 8'h40, 8'h60, 64'h00000100,
                  1'b0, 1'b0, 1'b0);

      Reset = 1'b1; Start = 1'b0; Op = '0; Length = '0; Carry_Init = 1'b0;
      Addr_A = '0; Addr_B = '0; Addr_Y = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_flags", {58'b0, Busy, Done, Error, Mem_Wr, Carry_Out, Zero_Out}, 64'd0);
      chk("rst_addrs", {40'b0, Mem_Addr_A, Mem_Addr_B, Mem_WrAddr}, 64'd0);
      Reset = 1'b0;

      for (int i = 0; i < 16; i++) run_vec(vt[i], i);

      // Descending walk across the 0xFF/0x00 boundary.
      run_vec(mk(4'hB, 2, 64'h0100, 64'h0, 1'b0, 8'hFF, 8'h20, 8'h70, 64'h0080, 1'b0, 1'b0, 1'b0), 16);

      // Reset in the middle of an 8-byte ADD.
      for (int i = 0; i < 8; i++) begin
         mem[8'h10 + 8'(i)] = 8'(8 - i);
         mem[8'h20 + 8'(i)] = 8'h10;
         mem[8'h30 + 8'(i)] = 8'hA5;
      end
      Op = 4'h2; Length = 3'd7; Carry_Init = 1'b0;
      Addr_A = 8'h10; Addr_B = 8'h20; Addr_Y = 8'h30; Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("mid_wr_active", 64'(Mem_Wr), 64'd1);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      chk("mid_rst_state", {61'b0, Mem_Wr, Busy, Done}, 64'd0);
      dn = 0;
      repeat (12) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Done || Mem_Wr) dn++;
      end
      chk("mid_rst_quiet", 64'(dn), 64'd0);
      chk("mid_rst_bytes", {40'b0, mem[8'h30], mem[8'h31], mem[8'h37]}, {40'b0, 8'h18, 8'h17, 8'hA5});
      run_vec(vt[4], 17);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multibyte_alu_seq.md
MULTIBYTE_ALU_SEQ -- requirements
Module: multibyte_alu_seq

Interface
REQ-001 SHALL have these ports: Clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have these ports: Reset  in  1  synchronous, active-high.
REQ-003 SHALL have these ports: Start  in  1  request; sampled only in IDLE.
REQ-004 SHALL have these ports: Op  in  4  CPU_Arith task code for the whole operation.
REQ-005 SHALL have these ports: Length  in  3  operand length in bytes minus 1 (N = Length+1, 1..8).
REQ-006 SHALL have these ports: Addr_A, Addr_B, Addr_Y  in  8 each  LSB-byte base addresses.
REQ-007 SHALL have these ports: Carry_Init  in  1  carry/borrow into the first byte.
REQ-008 SHALL have these ports: Mem_Addr_A, Mem_Addr_B  out  8  read addresses; data returns one cycle later on Mem_RdData_A, Mem_RdData_B  in  8.
REQ-009 SHALL have these ports: Mem_Wr  out  1, Mem_WrAddr  out  8, Mem_WrData  out  8  single-cycle byte write.
REQ-010 SHALL have these ports: Busy  out  1, Done  out  1 (one-cycle pulse), Error  out  1, Carry_Out  out  1, Zero_Out  out  1.

Function
REQ-011 SHALL sequence one internal CPU_Arith instance over N bytes, one byte per cycle.
REQ-012 SHALL accept Op in {1,2,3,5,6,7,8,9,A,B}; any other Op SHALL be illegal.
REQ-013 FSM states: IDLE, FETCH, RUN, DONE; IDLE->FETCH on Start with legal Op; IDLE->DONE on Start with illegal Op; FETCH->RUN; RUN->DONE after N cycles; DONE->IDLE.
REQ-014 All inputs except Mem_RdData SHALL be captured on the accepting edge; later changes are ignored until the next Start.
REQ-015 FETCH SHALL present byte 0 addresses; RUN cycle j SHALL consume byte j data, assert Mem_Wr with ALU result, and present byte j+1 addresses.
REQ-016 Byte order: ascending (base+j) for all ops except B; descending (base+N-1-j) for B; addresses wrap modulo 256.
REQ-017 First byte: ALU Carry_In = Carry_Init, task = Op.
REQ-018 Later bytes: task 2 issued as 1, task 8 issued as 7, others unchanged.
REQ-019 Later bytes, Carry_In: previous ALU Carry for 1,2,A,B; inverted previous ALU Carry for 7,8 (borrow-in convention); Carry_Init for logic ops.
REQ-020 Carry_Out SHALL be the last byte's ALU Carry (1 = no borrow for 7/8).
REQ-021 Zero_Out SHALL be 1 only if every result byte is 0x00.
REQ-022 Busy SHALL be high in FETCH and RUN only.
REQ-023 Done SHALL be high exactly in DONE; with accept at edge k, Done is at cycle k+N+2.
REQ-024 Illegal Op: Error=1 with Done; no Mem_Wr; Carry_Out and Zero_Out unchanged.
REQ-025 Error SHALL clear on the next accepted Start.
REQ-026 Addr_Y equal to Addr_A or Addr_B (in-place) SHALL give correct results; partial overlap is undefined.
REQ-027 Start while not IDLE SHALL be ignored.

Reset
REQ-028 Reset SHALL force IDLE; Busy, Done, Error, Mem_Wr, Carry_Out and Zero_Out SHALL be 0; addresses SHALL be 0.
REQ-029 Reset mid-RUN SHALL deassert Mem_Wr from the next edge; bytes already written remain, and no Done is issued.

Structure
REQ-030 A shared package SHALL hold the task-code constants (ADC=1, ADD=2, AND=3, NEG=4, NOT=5, OR=6, SBB=7, SUB=8, XOR=9, RLC=A, RRC=B), the legal-op set and the FSM state encoding.
REQ-031 CPU_Arith SHALL be the single sub-module; byte counter, carry register and zero accumulator SHALL be local.

Verification
REQ-032 ADD: op 2, N=2, A=0x00FF, B=0x0001, Carry_Init=0 -> Y=0x0100, Carry_Out=0, Zero_Out=0, Done at k+4.
REQ-033 ADD wrap: op 2, N=2, A=0xFFFF, B=0x0001 -> Y=0x0000, Carry_Out=1, Zero_Out=1.
REQ-034 SUB: op 8, N=2, A=0x0100, B=0x0001 -> Y=0x00FF, Carry_Out=1, Zero_Out=0; byte1 issued as task 7 with Carry_In=1.
REQ-035 RRC: op B, N=3, A=0x000001, Carry_Init=1 -> writes MSB first, Y=0x800000, Carry_Out=1, Zero_Out=0.
REQ-036 Illegal op 4 -> Done and Error one cycle after FETCH would start, no Mem_Wr; next legal Start clears Error.
REQ-037 Reset asserted in RUN of an N=8 ADD -> Mem_Wr=0 next cycle, IDLE, no Done; a new Start then runs normally.
